mldsa_seq_pc_gen: RTL



---
 rtl/mldsa_seq_pc_gen.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mldsa_seq_pc_gen.sv
// mldsa_seq_pc_gen - sequencer program-address generator.
//
// Walks a subroutine from a latched start address to a latched end address
// (inclusive), issuing one address per non-stalled cycle on the en/addr
// interface consumed by the sequencer ROMs and their debug decoders.
// In-range jumps, abort, stall and range-error reporting are supported.
//
// Parameters:
//   ADDR_W  program address width (equals MLDSA_PROG_ADDR_W)
//   CNT_W   width of the saturating step counter
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         start request (sampled only in IDLE)
//   start_addr_i    first address, sampled with start_i
//   end_addr_i      last address (inclusive), sampled with start_i
//   stall_i         hold the current address
//   jump_i          jump request, held by the requester until accepted
//   jump_addr_i     jump target
//   abort_i         terminate the walk without done
//   en_o, addr_o    address valid / program address
//   busy_o          high while walking
//   done_o          one-cycle pulse on normal completion
//   err_o           sticky range error, cleared by the next accepted start
//   step_cnt_o      accepted steps since the last start
//
// Optional feature macro: MLDSA_SEQ_PC_TRACE_EN
//   Adds a 26-bit free-running cycle counter plus outputs addr_chg_o (pulse
//   when a newly issued address differs from the previously issued one) and
//   chg_cyc_o (cycle count captured at the last such pulse).

module mldsa_seq_pc_gen #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] end_addr_i,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              abort_i,
  output logic              en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  step_cnt_o
`ifdef MLDSA_SEQ_PC_TRACE_EN
  ,
  output logic              addr_chg_o,
  output logic [25:0]       chg_cyc_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   lo_r, hi_r, lo_s, hi_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                en_r, en_s;
  logic                done_r, done_s;
  logic                err_r, err_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s, cnt_inc_s;

  // Saturating increment of the step counter.
  always_comb begin
    if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic; RUN priority is abort > stall > jump > advance.
  always_comb begin
    state_s = state_r;
    lo_s    = lo_r;
    hi_s    = hi_r;
    addr_s  = addr_r;
    en_s    = en_r;
    done_s  = 1'b0;
    err_s   = err_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (start_addr_i <= end_addr_i) begin
            lo_s    = start_addr_i;
            hi_s    = end_addr_i;
            addr_s  = start_addr_i;
            en_s    = 1'b1;
            cnt_s   = {CNT_W{1'b0}};
            err_s   = 1'b0;
            state_s = ST_RUN;
          end else begin
            err_s   = 1'b1;
            state_s = ST_ERR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          en_s    = 1'b0;
          state_s = ST_IDLE;
        end else if (stall_i) begin
          state_s = ST_RUN;
        end else if (jump_i) begin
          if ((jump_addr_i >= lo_r) && (jump_addr_i <= hi_r)) begin
            addr_s = jump_addr_i;
            cnt_s  = cnt_inc_s;
          end else begin
            en_s    = 1'b0;
            err_s   = 1'b1;
            state_s = ST_ERR;
          end
        end else if (addr_r == hi_r) begin
          // End compare precedes the increment, so hi = all ones never wraps.
          en_s    = 1'b0;
          done_s  = 1'b1;
          cnt_s   = cnt_inc_s;
          state_s = ST_DONE;
        end else begin
          addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          cnt_s  = cnt_inc_s;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      ST_ERR: begin
        state_s = ST_IDLE;
      end
      default: begin
        en_s    = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      lo_r    <= {ADDR_W{1'b0}};
      hi_r    <= {ADDR_W{1'b0}};
      addr_r  <= {ADDR_W{1'b1}};
      en_r    <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      lo_r    <= lo_s;
      hi_r    <= hi_s;
      addr_r  <= addr_s;
      en_r    <= en_s;
      done_r  <= done_s;
      err_r   <= err_s;
      cnt_r   <= cnt_s;
    end
  end

  assign en_o       = en_r;
  assign addr_o     = addr_r;
  assign busy_o     = (state_r == ST_RUN);
  assign done_o     = done_r;
  assign err_o      = err_r;
  assign step_cnt_o = cnt_r;

`ifdef MLDSA_SEQ_PC_TRACE_EN
  logic [25:0]       cyc_r;
  logic [25:0]       chg_cyc_r;
  logic [ADDR_W-1:0] last_addr_r;
  logic              seen_r;
  logic              chg_r;

  // Address-change tracer; seen_r forces a pulse on the first issue after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_r       <= 26'd0;
      chg_cyc_r   <= 26'd0;
      last_addr_r <= {ADDR_W{1'b0}};
      seen_r      <= 1'b0;
      chg_r       <= 1'b0;
    end else begin
      cyc_r <= cyc_r + 26'd1;
      if (en_s && (!seen_r || (addr_s != last_addr_r))) begin
        chg_r       <= 1'b1;
        last_addr_r <= addr_s;
        seen_r      <= 1'b1;
        chg_cyc_r   <= cyc_r + 26'd1;
      end else begin
        chg_r <= 1'b0;
      end
    end
  end

  assign addr_chg_o = chg_r;
  assign chg_cyc_o  = chg_cyc_r;
`endif

endmodule
